// File: rtl/id_ex_operand_stage_if.sv
// Signal bundle between the decode stage and the ID/EX operand stage.
// master = decode/forwarding sources, slave = the operand stage.
interface id_ex_operand_stage_if #(
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned CNT_W = 16
) ();
  logic          id_valid;
  logic [AW-1:0] id_rs;
  logic [AW-1:0] id_rt;
  logic [AW-1:0] id_rd;
  logic          id_uses_rs;
  logic          id_uses_rt;
  logic          id_is_load;
  logic          id_reg_write;
  logic [DW-1:0] rf_a;
  logic [DW-1:0] rf_b;
  logic [DW-1:0] ex_fwd_data;
  logic          mem_reg_write;
  logic [AW-1:0] mem_rd;
  logic [DW-1:0] mem_fwd_data;
  logic          wb_reg_write;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          flush;

  logic             stall;
  logic             ex_valid;
  logic [DW-1:0]    ex_a;
  logic [DW-1:0]    ex_b;
  logic [AW-1:0]    ex_rd;
  logic             ex_is_load;
  logic             ex_reg_write;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt, id_is_load, id_reg_write,
    output rf_a, rf_b, ex_fwd_data, mem_reg_write, mem_rd, mem_fwd_data,
    output wb_reg_write, wb_rd, wb_data, flush,
    input  stall, ex_valid, ex_a, ex_b, ex_rd, ex_is_load, ex_reg_write, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt, id_is_load, id_reg_write,
    input  rf_a, rf_b, ex_fwd_data, mem_reg_write, mem_rd, mem_fwd_data,
    input  wb_reg_write, wb_rd, wb_data, flush,
    output stall, ex_valid, ex_a, ex_b, ex_rd, ex_is_load, ex_reg_write, stall_count
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: forwarding from EX/MEM/WB, load-use stall detection,
// and the ID/EX pipeline register with a saturating bubble counter.
module id_ex_operand_stage #(
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned CNT_W = 16
) (
  input logic              clk,
  input logic              rst_n,
  id_ex_operand_stage_if.slave bus
);

  logic             ex_valid_q;
  logic [DW-1:0]    ex_a_q;
  logic [DW-1:0]    ex_b_q;
  logic [AW-1:0]    ex_rd_q;
  logic             ex_is_load_q;
  logic             ex_reg_write_q;
  logic [CNT_W-1:0] stall_count_q;

  logic          ex_hit_s;
  logic          ex_hit_t;
  logic          stall_c;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;

  assign ex_hit_s = ex_valid_q & ex_reg_write_q & (ex_rd_q != '0) & (ex_rd_q == bus.id_rs);
  assign ex_hit_t = ex_valid_q & ex_reg_write_q & (ex_rd_q != '0) & (ex_rd_q == bus.id_rt);

  assign stall_c = bus.id_valid & ~bus.flush & ex_is_load_q &
                   ((bus.id_uses_rs & ex_hit_s) | (bus.id_uses_rt & ex_hit_t));

  // WB wins over rf because the register file only commits on this same edge.
  function automatic logic [DW-1:0] sel_operand(input logic [AW-1:0] idx,
                                                input logic [DW-1:0] rf,
                                                input logic          ex_hit);
    logic [DW-1:0] res;
    res = rf;
    if (idx == '0) begin
      res = rf;
    end else if (ex_hit && !ex_is_load_q) begin
      res = bus.ex_fwd_data;
    end else if (bus.mem_reg_write && (bus.mem_rd == idx)) begin
      res = bus.mem_fwd_data;
    end else if (bus.wb_reg_write && (bus.wb_rd == idx)) begin
      res = bus.wb_data;
    end
    return res;
  endfunction

  always_comb begin
    op_a = sel_operand(bus.id_rs, bus.rf_a, ex_hit_s);
    op_b = sel_operand(bus.id_rt, bus.rf_b, ex_hit_t);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q     <= 1'b0;
      ex_a_q         <= '0;
      ex_b_q         <= '0;
      ex_rd_q        <= '0;
      ex_is_load_q   <= 1'b0;
      ex_reg_write_q <= 1'b0;
      stall_count_q  <= '0;
    end else if (bus.flush) begin
      ex_valid_q     <= 1'b0;
      ex_is_load_q   <= 1'b0;
      ex_reg_write_q <= 1'b0;
    end else if (stall_c) begin
      ex_valid_q     <= 1'b0;
      ex_is_load_q   <= 1'b0;
      ex_reg_write_q <= 1'b0;
      if (stall_count_q != {CNT_W{1'b1}}) begin
        stall_count_q <= stall_count_q + CNT_W'(1);
      end
    end else begin
      ex_valid_q     <= bus.id_valid;
      ex_a_q         <= op_a;
      ex_b_q         <= op_b;
      ex_rd_q        <= bus.id_rd;
      ex_is_load_q   <= bus.id_is_load & bus.id_valid;
      ex_reg_write_q <= bus.id_reg_write & bus.id_valid;
    end
  end

  assign bus.stall        = stall_c;
  assign bus.ex_valid     = ex_valid_q;
  assign bus.ex_a         = ex_a_q;
  assign bus.ex_b         = ex_b_q;
  assign bus.ex_rd        = ex_rd_q;
  assign bus.ex_is_load   = ex_is_load_q;
  assign bus.ex_reg_write = ex_reg_write_q;
  assign bus.stall_count  = stall_count_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed scenarios plus random traffic checked
// against a cycle-level behavioural model of the pipeline register.
module tb_id_ex_operand_stage;
  // Narrow counter so saturation is reachable in a short run.
  localparam int unsigned CW  = 6;
  localparam int          SAT = (1 << CW) - 1;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;

  id_ex_operand_stage_if #(.DW(32), .AW(5), .CNT_W(CW)) bus ();

  id_ex_operand_stage #(.DW(32), .AW(5), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the ID/EX register contents.
  logic        m_valid;
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic [4:0]  m_rd;
  logic        m_load;
  logic        m_wr;
  int          m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic model_stall();
    logic hs;
    logic ht;
    hs = m_valid && m_wr && m_load && (bus.id_rs != 0) && (bus.id_rs == m_rd);
    ht = m_valid && m_wr && m_load && (bus.id_rt != 0) && (bus.id_rt == m_rd);
    return bus.id_valid && !bus.flush && ((bus.id_uses_rs && hs) || (bus.id_uses_rt && ht));
  endfunction

  function automatic logic [31:0] model_opnd(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 0) return rf;
    if (m_valid && m_wr && !m_load && (m_rd == idx)) return bus.ex_fwd_data;
    if (bus.mem_reg_write && (bus.mem_rd == idx)) return bus.mem_fwd_data;
    if (bus.wb_reg_write && (bus.wb_rd == idx)) return bus.wb_data;
    return rf;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_a = 0; m_b = 0; m_rd = 0; m_load = 0; m_wr = 0; m_cnt = 0;
  endtask

  task automatic clear_inputs();
    bus.id_valid = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0;
    bus.id_uses_rs = 0; bus.id_uses_rt = 0; bus.id_is_load = 0; bus.id_reg_write = 0;
    bus.rf_a = 0; bus.rf_b = 0; bus.ex_fwd_data = 0;
    bus.mem_reg_write = 0; bus.mem_rd = 0; bus.mem_fwd_data = 0;
    bus.wb_reg_write = 0; bus.wb_rd = 0; bus.wb_data = 0; bus.flush = 0;
  endtask

  // Called just after a negedge with inputs applied; returns just after the next negedge.
  task automatic tick();
    logic        s;
    logic [31:0] na;
    logic [31:0] nb;
    #1;
    s  = model_stall();
    na = model_opnd(bus.id_rs, bus.rf_a);
    nb = model_opnd(bus.id_rt, bus.rf_b);
    chk("stall", bus.stall, s);
    if (bus.flush || s) begin
      m_valid = 0; m_load = 0; m_wr = 0;
      if (!bus.flush && m_cnt < SAT) m_cnt++;
    end else begin
      m_valid = bus.id_valid;
      m_a = na; m_b = nb; m_rd = bus.id_rd;
      m_load = bus.id_is_load && bus.id_valid;
      m_wr = bus.id_reg_write && bus.id_valid;
    end
    @(posedge clk);
    #1;
    chk("ex_valid", bus.ex_valid, m_valid);
    chk("ex_is_load", bus.ex_is_load, m_load);
    chk("ex_reg_write", bus.ex_reg_write, m_wr);
    chk("stall_count", bus.stall_count, m_cnt);
    if (m_valid) begin
      chk("ex_a", bus.ex_a, m_a);
      chk("ex_b", bus.ex_b, m_b);
      chk("ex_rd", bus.ex_rd, m_rd);
    end
    @(negedge clk);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    clear_inputs();
    model_reset();
    rst_n = 0;
    #12;
    chk("rst_ex_valid", bus.ex_valid, 0);
    chk("rst_ex_a", bus.ex_a, 0);
    chk("rst_ex_reg_write", bus.ex_reg_write, 0);
    chk("rst_stall_count", bus.stall_count, 0);
    chk("rst_stall", bus.stall, 0);
    @(negedge clk);
    rst_n = 1;

    // Plain pass-through.
    bus.id_valid = 1; bus.id_rs = 1; bus.id_rt = 2; bus.id_rd = 5;
    bus.id_uses_rs = 1; bus.id_uses_rt = 1; bus.rf_a = 5; bus.rf_b = 7;
    tick();
    chk("plain_a", bus.ex_a, 5);
    chk("plain_b", bus.ex_b, 7);
    chk("plain_valid", bus.ex_valid, 1);

    // EX forward beats MEM and WB.
    clear_inputs();
    bus.id_valid = 1; bus.id_rd = 3; bus.id_reg_write = 1;
    tick();
    clear_inputs();
    bus.id_valid = 1; bus.id_rs = 3; bus.id_uses_rs = 1; bus.ex_fwd_data = 32'h11;
    tick();
    chk("exfwd_a", bus.ex_a, 32'h11);
    clear_inputs();
    bus.id_valid = 1; bus.id_rd = 3; bus.id_reg_write = 1;
    tick();
    clear_inputs();
    bus.id_valid = 1; bus.id_rs = 3; bus.id_uses_rs = 1; bus.ex_fwd_data = 32'h11;
    bus.mem_reg_write = 1; bus.mem_rd = 3; bus.mem_fwd_data = 32'h22;
    bus.wb_reg_write = 1; bus.wb_rd = 3; bus.wb_data = 32'h33;
    tick();
    chk("exfwd_prio_a", bus.ex_a, 32'h11);

    // Load-use: one bubble, then MEM supplies the loaded value.
    clear_inputs();
    bus.id_valid = 1; bus.id_rd = 4; bus.id_reg_write = 1; bus.id_is_load = 1;
    tick();
    clear_inputs();
    bus.id_valid = 1; bus.id_rt = 4; bus.id_uses_rt = 1;
    #1 chk("lu_stall", bus.stall, 1);
    tick();
    chk("lu_bubble", bus.ex_valid, 0);
    chk("lu_count", bus.stall_count, 1);
    bus.mem_reg_write = 1; bus.mem_rd = 4; bus.mem_fwd_data = 32'h99;
    #1 chk("lu_release", bus.stall, 0);
    tick();
    chk("lu_b", bus.ex_b, 32'h99);

    // WB bypass over a stale register file, and r0 never forwards.
    clear_inputs();
    bus.id_valid = 1; bus.id_rs = 9; bus.id_uses_rs = 1;
    bus.wb_reg_write = 1; bus.wb_rd = 9; bus.wb_data = 32'hABCD;
    tick();
    chk("wb_a", bus.ex_a, 32'hABCD);
    clear_inputs();
    bus.id_valid = 1; bus.id_uses_rs = 1; bus.rf_a = 32'h1234; bus.ex_fwd_data = 32'h5;
    bus.mem_reg_write = 1; bus.wb_reg_write = 1; bus.mem_fwd_data = 32'h6; bus.wb_data = 32'h7;
    tick();
    chk("r0_a", bus.ex_a, 32'h1234);

    // Flush overrides a pending load-use stall.
    clear_inputs();
    bus.id_valid = 1; bus.id_rd = 4; bus.id_reg_write = 1; bus.id_is_load = 1;
    tick();
    clear_inputs();
    bus.id_valid = 1; bus.id_rt = 4; bus.id_uses_rt = 1; bus.flush = 1;
    #1 chk("flush_stall", bus.stall, 0);
    tick();
    chk("flush_valid", bus.ex_valid, 0);
    chk("flush_count", bus.stall_count, 1);

    // Random traffic; small index range keeps hazards frequent.
    for (int i = 0; i < 400; i++) begin
      bus.id_valid      = ($urandom_range(0, 7) != 0);
      bus.id_rs         = 5'($urandom_range(0, 3));
      bus.id_rt         = 5'($urandom_range(0, 3));
      bus.id_rd         = 5'($urandom_range(0, 3));
      bus.id_uses_rs    = 1'($urandom);
      bus.id_uses_rt    = 1'($urandom);
      bus.id_is_load    = ($urandom_range(0, 2) == 0);
      bus.id_reg_write  = 1'($urandom);
      bus.rf_a          = $urandom;
      bus.rf_b          = $urandom;
      bus.ex_fwd_data   = $urandom;
      bus.mem_reg_write = 1'($urandom);
      bus.mem_rd        = 5'($urandom_range(0, 3));
      bus.mem_fwd_data  = $urandom;
      bus.wb_reg_write  = 1'($urandom);
      bus.wb_rd         = 5'($urandom_range(0, 3));
      bus.wb_data       = $urandom;
      bus.flush         = ($urandom_range(0, 7) == 0);
      tick();
    end

    // A self-dependent load stalls every other cycle; drive the counter into saturation.
    clear_inputs();
    bus.id_valid = 1; bus.id_rs = 4; bus.id_uses_rs = 1; bus.id_rd = 4;
    bus.id_is_load = 1; bus.id_reg_write = 1;
    for (int i = 0; i < 2 * SAT + 20; i++) tick();
    chk("sat_count", bus.stall_count, SAT);

    // Async reset in the middle of a stall cycle.
    if (!model_stall()) tick();
    #1 chk("pre_rst_stall", bus.stall, 1);
    #2 rst_n = 0;
    #1;
    model_reset();
    chk("mid_rst_valid", bus.ex_valid, 0);
    chk("mid_rst_load", bus.ex_is_load, 0);
    chk("mid_rst_rd", bus.ex_rd, 0);
    chk("mid_rst_a", bus.ex_a, 0);
    chk("mid_rst_count", bus.stall_count, 0);
    chk("mid_rst_stall", bus.stall, 0);
    @(negedge clk);
    rst_n = 1;
    tick();
    chk("post_rst_valid", bus.ex_valid, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
